// File: rtl/register_bank_fwd.sv
// Decode-stage register file: 32 x DW GPRs (R0 hardwired zero) with one
// write port from DM, forwarding muxes for EX operands A/B, and registered outputs.
module register_bank_fwd #(
  parameter int DW = 16,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] ans_ex,
  input  logic [DW-1:0] ans_dm,
  input  logic [DW-1:0] ans_wb,
  input  logic [DW-1:0] imm,
  input  logic [AW-1:0] RA,
  input  logic [AW-1:0] RB,
  input  logic [AW-1:0] RW_dm,
  input  logic [1:0]    mux_sel_A,
  input  logic [1:0]    mux_sel_B,
  input  logic          imm_sel,
  output logic [DW-1:0] A,
  output logic [DW-1:0] B
);

  localparam int NREG = 1 << AW;

  typedef enum logic [1:0] {
    SEL_REG = 2'b00,
    SEL_EX  = 2'b01,
    SEL_DM  = 2'b10,
    SEL_WB  = 2'b11
  } fwd_sel_e;

  logic [DW-1:0] r_regs [NREG];
  logic [DW-1:0] r_a;
  logic [DW-1:0] r_b;

  logic [DW-1:0] w_rd_a;
  logic [DW-1:0] w_rd_b;
  logic [DW-1:0] w_mux_a;
  logic [DW-1:0] w_mux_b;

  // Write-first read: the DM-stage write lands this edge, so a matching read
  // returns ans_dm directly. R0 always reads zero, bypass included.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_rd_a = r_regs[RA];
    if (RA == '0)         w_rd_a = '0;
    else if (RA == RW_dm) w_rd_a = ans_dm;

    w_rd_b = r_regs[RB];
    if (RB == '0)         w_rd_b = '0;
    else if (RB == RW_dm) w_rd_b = ans_dm;
  end

  always_comb begin
    w_mux_a = w_rd_a;
    unique case (fwd_sel_e'(mux_sel_A))
      SEL_REG: w_mux_a = w_rd_a;
      SEL_EX:  w_mux_a = ans_ex;
      SEL_DM:  w_mux_a = ans_dm;
      SEL_WB:  w_mux_a = ans_wb;
      default: w_mux_a = w_rd_a;
    endcase

    w_mux_b = w_rd_b;
    unique case (fwd_sel_e'(mux_sel_B))
      SEL_REG: w_mux_b = w_rd_b;
      SEL_EX:  w_mux_b = ans_ex;
      SEL_DM:  w_mux_b = ans_dm;
      SEL_WB:  w_mux_b = ans_wb;
      default: w_mux_b = w_rd_b;
    endcase
    if (imm_sel) w_mux_b = imm;
  end

  // NOTE: the whole register array is cleared on reset, so it maps to flops rather than a RAM macro.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
      r_a <= '0;
      r_b <= '0;
    end else begin
      if (RW_dm != '0) r_regs[RW_dm] <= ans_dm;
      r_a <= w_mux_a;
      r_b <= w_mux_b;
    end
  end

  assign A = r_a;
  assign B = r_b;

endmodule

// File: tb/tb_register_bank_fwd.sv
// Directed self-checking bench for register_bank_fwd: reset, read/write,
// forwarding muxes, immediate override, R0, write-first bypass and mid-stream reset.
module tb_register_bank_fwd;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] ans_ex = '0, ans_dm = '0, ans_wb = '0, imm = '0;
  logic [4:0]  RA = '0, RB = '0, RW_dm = '0;
  logic [1:0]  mux_sel_A = '0, mux_sel_B = '0;
  logic        imm_sel = 1'b0;
  logic [15:0] A, B;

  int n_cmp = 0;
  int n_err = 0;

  register_bank_fwd #(.DW(16), .AW(5)) dut (
    .clk(clk), .rst(rst),
    .ans_ex(ans_ex), .ans_dm(ans_dm), .ans_wb(ans_wb), .imm(imm),
    .RA(RA), .RB(RB), .RW_dm(RW_dm),
    .mux_sel_A(mux_sel_A), .mux_sel_B(mux_sel_B), .imm_sel(imm_sel),
    .A(A), .B(B)
  );

  always #5 clk = ~clk;

  // Advance one rising edge, then settle 1 time unit before sampling/driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    // 1. reset, then every address reads zero on both ports
    rst = 1'b1;
    tick();
    tick();
    check("rst_A", A, 16'h0000);
    check("rst_B", B, 16'h0000);
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      RA = 5'(i);
      RB = 5'(31 - i);
      tick();
      check($sformatf("zero_A_r%0d", i), A, 16'h0000);
      check($sformatf("zero_B_r%0d", 31 - i), B, 16'h0000);
    end

    // 2. write R7, read back on B; unwritten R5 on A
    ans_dm = 16'hD000; RW_dm = 5'd7; RA = 5'd0; RB = 5'd0;
    tick();
    RW_dm = 5'd0; RB = 5'd7; RA = 5'd5; mux_sel_B = 2'b00;
    ans_dm = 16'h0000;
    tick();
    check("rd_R7_B", B, 16'hD000);
    check("rd_R5_A", A, 16'h0000);

    // 3. forwarding sources
    ans_ex = 16'hC000; ans_dm = 16'hD000; ans_wb = 16'hE000;
    mux_sel_A = 2'b10; mux_sel_B = 2'b01;
    tick();
    check("fwd_A_dm", A, 16'hD000);
    check("fwd_B_ex", B, 16'hC000);
    mux_sel_A = 2'b11; mux_sel_B = 2'b11;
    tick();
    check("fwd_A_wb", A, 16'hE000);
    check("fwd_B_wb", B, 16'hE000);
    mux_sel_A = 2'b01; mux_sel_B = 2'b10;
    tick();
    check("fwd_A_ex", A, 16'hC000);
    check("fwd_B_dm", B, 16'hD000);

    // 4. immediate overrides every B select
    imm = 16'hFFFF; imm_sel = 1'b1;
    for (int s = 0; s < 4; s++) begin
      mux_sel_B = 2'(s);
      tick();
      check($sformatf("imm_B_sel%0d", s), B, 16'hFFFF);
    end
    imm_sel = 1'b0; mux_sel_B = 2'b01;
    tick();
    check("imm_off_B", B, 16'hC000);

    // 5. R0 immutable, bypass excluded for R0; write-first bypass on A and B
    mux_sel_A = 2'b00; mux_sel_B = 2'b00;
    RW_dm = 5'd0; ans_dm = 16'h1234; RA = 5'd0; RB = 5'd7;
    tick();
    check("r0_A_same", A, 16'h0000);
    check("r7_B_keep", B, 16'hD000);
    ans_dm = 16'h0000;
    tick();
    check("r0_A_after", A, 16'h0000);
    RA = 5'd9; RW_dm = 5'd9; ans_dm = 16'hBEEF;
    tick();
    check("byp_A_r9", A, 16'hBEEF);
    RW_dm = 5'd12; ans_dm = 16'h5A5A; RB = 5'd12;
    tick();
    check("byp_B_r12", B, 16'h5A5A);
    check("r9_A_held", A, 16'hBEEF);
    RW_dm = 5'd0; ans_dm = 16'h0000; RA = 5'd12; RB = 5'd12;
    tick();
    check("same_A_r12", A, 16'h5A5A);
    check("same_B_r12", B, 16'h5A5A);

    // 6. mid-stream reset discards write and output update
    RA = 5'd7; RB = 5'd9;
    tick();
    check("pre_rst_A_r7", A, 16'hD000);
    check("pre_rst_B_r9", B, 16'hBEEF);
    rst = 1'b1; RW_dm = 5'd3; ans_dm = 16'h7777; mux_sel_A = 2'b01;
    tick();
    check("mid_rst_A", A, 16'h0000);
    check("mid_rst_B", B, 16'h0000);
    rst = 1'b0; RW_dm = 5'd0; ans_dm = 16'h0000; mux_sel_A = 2'b00;
    RA = 5'd7; RB = 5'd3;
    tick();
    check("post_rst_r7", A, 16'h0000);
    check("post_rst_r3", B, 16'h0000);
    RA = 5'd9; RB = 5'd12;
    tick();
    check("post_rst_r9", A, 16'h0000);
    check("post_rst_r12", B, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
